// File: rtl/flash_reader_pkg.sv
// Shared types and constants for the boot-time SPI flash copier.
package flash_reader_pkg;

  typedef enum logic [2:0] {
    Idle,
    SendCommand,
    SendAddress,
    SendDummy,
    ReceiveData,
    Finish
  } state_e;

  localparam logic [7:0] CmdRead      = 8'h03;
  localparam logic [7:0] CmdFastRead  = 8'h0B;
  localparam int         DummyBits    = 8;
  localparam int         CmdBits      = 8;
  localparam int         AddrWireBits = 24;

endpackage

// File: rtl/flash_word_packer.sv
// Packs received bytes little-endian into 32-bit words and issues one-cycle RAM write strobes.
`default_nettype none

module flash_word_packer #(
  parameter int RamAddressBitWidth = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          init_i,
  input  logic [RamAddressBitWidth-1:0] base_address_i,
  input  logic [7:0]                    byte_i,
  input  logic                          valid_i,
  input  logic                          last_i,
  output logic [RamAddressBitWidth-1:0] ram_address_o,
  output logic [31:0]                   ram_data_o,
  output logic [3:0]                    ram_write_enable_o
);

  logic [1:0]                    lane_q;
  logic [31:0]                   acc_q;
  logic [3:0]                    mask_q;
  logic [RamAddressBitWidth-1:0] next_addr_q;
  logic [RamAddressBitWidth-1:0] ram_address_q;
  logic [31:0]                   data_q;
  logic [3:0]                    we_q;

  logic [31:0] packed_word;
  logic [3:0]  packed_mask;
  logic        flush;

  assign packed_word = acc_q | ({24'b0, byte_i} << {lane_q, 3'b000});
  assign packed_mask = mask_q | (4'b0001 << lane_q);
  // A word is written when lane 3 fills or the transfer's final byte arrives.
  assign flush       = valid_i && ((lane_q == 2'd3) || last_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q        <= '0;
      acc_q         <= '0;
      mask_q        <= '0;
      next_addr_q   <= '0;
      ram_address_q <= '0;
      data_q        <= '0;
      we_q          <= '0;
    end else begin
      we_q <= '0;
      if (init_i) begin
        lane_q      <= '0;
        acc_q       <= '0;
        mask_q      <= '0;
        next_addr_q <= base_address_i;
      end else if (flush) begin
        data_q        <= packed_word;
        we_q          <= packed_mask;
        ram_address_q <= next_addr_q;
        next_addr_q   <= next_addr_q + 1'b1;
        lane_q        <= '0;
        acc_q         <= '0;
        mask_q        <= '0;
      end else if (valid_i) begin
        acc_q  <= packed_word;
        mask_q <= packed_mask;
        lane_q <= lane_q + 2'd1;
      end
    end
  end

  assign ram_address_o      = ram_address_q;
  assign ram_data_o         = data_q;
  assign ram_write_enable_o = we_q;

endmodule

`default_nettype wire

// File: rtl/flash_reader.sv
// SPI mode-0 master copying a flash byte range into RAM at boot.
// Build option: FLASH_READER_FAST_READ_EN selects command 0x0B with 8 dummy bits.
`default_nettype none

module flash_reader
  import flash_reader_pkg::*;
#(
  parameter int FlashAddressBitWidth = 24,
  parameter int RamAddressBitWidth   = 16,
  parameter int CountBitWidth        = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start_i,
  input  logic [FlashAddressBitWidth-1:0] flash_address_i,
  input  logic [RamAddressBitWidth-1:0]   ram_address_start_i,
  input  logic [CountBitWidth-1:0]        byte_count_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            flash_cs_o,
  output logic                            flash_clk_o,
  output logic                            flash_mosi_o,
  input  logic                            flash_miso_i,
  output logic [RamAddressBitWidth-1:0]   ram_address_o,
  output logic [31:0]                     ram_data_o,
  output logic [3:0]                      ram_write_enable_o
);

`ifdef FLASH_READER_FAST_READ_EN
  localparam logic [7:0] ReadCmd = CmdFastRead;
`else
  localparam logic [7:0] ReadCmd = CmdRead;
`endif

  state_e                   state_q, state_d;
  logic                     phase_q, phase_d;
  logic [4:0]               bit_cnt_q, bit_cnt_d;
  logic [31:0]              tx_q, tx_d;
  logic [7:0]               rx_q, rx_d;
  logic [CountBitWidth-1:0] count_q, count_d;
  logic                     done_q, done_d;

  logic byte_valid;
  logic byte_last;
  logic packer_init;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= Idle;
      phase_q   <= 1'b0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      count_q   <= count_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    count_d     = count_q;
    done_d      = 1'b0;
    byte_valid  = 1'b0;
    byte_last   = 1'b0;
    packer_init = 1'b0;

    case (state_q)
      Idle: begin
        phase_d = 1'b0;
        if (start_i) begin
          if (byte_count_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = SendCommand;
            tx_d        = {ReadCmd, AddrWireBits'(flash_address_i)};
            bit_cnt_d   = '0;
            count_d     = byte_count_i;
            packer_init = 1'b1;
          end
        end
      end

      SendCommand, SendAddress, SendDummy, ReceiveData: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          // End of phase H: one SPI bit completes on this edge.
          phase_d   = 1'b0;
          bit_cnt_d = bit_cnt_q + 5'd1;
          case (state_q)
            SendCommand: begin
              tx_d = {tx_q[30:0], 1'b0};
              if (bit_cnt_q == 5'(CmdBits - 1)) begin
                state_d   = SendAddress;
                bit_cnt_d = '0;
              end
            end
            SendAddress: begin
              tx_d = {tx_q[30:0], 1'b0};
              if (bit_cnt_q == 5'(AddrWireBits - 1)) begin
                bit_cnt_d = '0;
`ifdef FLASH_READER_FAST_READ_EN
                state_d   = SendDummy;
`else
                state_d   = ReceiveData;
`endif
              end
            end
            SendDummy: begin
              if (bit_cnt_q == 5'(DummyBits - 1)) begin
                state_d   = ReceiveData;
                bit_cnt_d = '0;
              end
            end
            default: begin
              rx_d = {rx_q[6:0], flash_miso_i};
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_d  = '0;
                byte_valid = 1'b1;
                count_d    = count_q - 1'b1;
                if (count_q == CountBitWidth'(1)) begin
                  byte_last = 1'b1;
                  state_d   = Finish;
                end
              end
            end
          endcase
        end
      end

      Finish: begin
        state_d = Idle;
        done_d  = 1'b1;
      end

      default: state_d = Idle;
    endcase
  end

  // Pin outputs decode straight from state so an async reset releases the bus at once.
  assign flash_cs_o   = !(state_q inside {SendCommand, SendAddress, SendDummy, ReceiveData});
  assign flash_clk_o  = phase_q;
  assign flash_mosi_o = ((state_q == SendCommand) || (state_q == SendAddress)) && tx_q[31];
  assign busy_o       = (state_q != Idle);
  assign done_o       = done_q;

  flash_word_packer #(
    .RamAddressBitWidth(RamAddressBitWidth)
  ) u_packer (
    .clk               (clk),
    .rst_n             (rst_n),
    .init_i            (packer_init),
    .base_address_i    (ram_address_start_i),
    .byte_i            (rx_d),
    .valid_i           (byte_valid),
    .last_i            (byte_last),
    .ram_address_o     (ram_address_o),
    .ram_data_o        (ram_data_o),
    .ram_write_enable_o(ram_write_enable_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_flash_reader.sv
// Bench for flash_reader: SPI flash emulator (byte i = i[7:0]) plus a RAM-write reference model.
`timescale 1ns/1ps

module tb_flash_reader;

  localparam int RA = 16;
  localparam int CB = 16;
`ifdef FLASH_READER_FAST_READ_EN
  localparam int         HDR = 40;
  localparam logic [7:0] CMD = 8'h0B;
`else
  localparam int         HDR = 32;
  localparam logic [7:0] CMD = 8'h03;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [23:0]   flash_address = '0;
  logic [RA-1:0] ram_start = '0;
  logic [CB-1:0] byte_count = '0;
  logic          busy, done, flash_cs, flash_clk, flash_mosi;
  logic          flash_miso = 1'b0;
  logic [RA-1:0] ram_address;
  logic [31:0]   ram_data;
  logic [3:0]    ram_we;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  flash_reader #(
    .FlashAddressBitWidth(24),
    .RamAddressBitWidth  (RA),
    .CountBitWidth       (CB)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start_i            (start),
    .flash_address_i    (flash_address),
    .ram_address_start_i(ram_start),
    .byte_count_i       (byte_count),
    .busy_o             (busy),
    .done_o             (done),
    .flash_cs_o         (flash_cs),
    .flash_clk_o        (flash_clk),
    .flash_mosi_o       (flash_mosi),
    .flash_miso_i       (flash_miso),
    .ram_address_o      (ram_address),
    .ram_data_o         (ram_data),
    .ram_write_enable_o (ram_we)
  );

  // Flash emulator: captures the header on rising SCK, shifts data out on falling SCK.
  int          rises = 0;
  logic [39:0] hdr = '0;

  always @(posedge flash_clk or posedge flash_cs) begin
    if (flash_cs) begin
      rises = 0;
    end else begin
      if (rises < HDR) hdr = {hdr[38:0], flash_mosi};
      rises = rises + 1;
    end
  end

  always @(negedge flash_clk) begin
    int          idx;
    logic [23:0] a;
    logic [7:0]  b;
    if (!flash_cs && rises >= HDR) begin
      idx = rises - HDR;
      a   = hdr[HDR-9 -: 24] + 24'(idx / 8);
      b   = a[7:0];
      flash_miso <= b[7 - (idx % 8)];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [RA-1:0] a;
    logic [31:0]   d;
    logic [3:0]    we;
  } wr_t;

  wr_t exp_q[$];

  task automatic run_xfer(input logic [23:0] fa, input int cnt, input logic [RA-1:0] rs,
                          input bit idle_after, input bit poke, input int abort_at);
    int          n, lat, nwr;
    bit          got_done, cs_low;
    wr_t         e;
    logic [23:0] ba;
    logic [39:0] eh;

    // Reference: byte k of the range lands in word k/4, lane k%4.
    exp_q.delete();
    for (int w = 0; w * 4 < cnt; w++) begin
      e.a  = rs + RA'(w);
      e.d  = '0;
      e.we = '0;
      for (int l = 0; l < 4 && (w * 4 + l) < cnt; l++) begin
        ba = fa + 24'(w * 4 + l);
        e.d[8*l +: 8] = ba[7:0];
        e.we[l] = 1'b1;
      end
      exp_q.push_back(e);
    end
    lat = (cnt == 0) ? 2 : (3 + 2 * HDR + 16 * cnt);
`ifdef FLASH_READER_FAST_READ_EN
    eh = {CMD, fa, 8'h00};
`else
    eh = {8'h00, CMD, fa};
`endif

    flash_address = fa;
    byte_count    = CB'(cnt);
    ram_start     = rs;
    start         = 1'b1;
    n = 0; nwr = 0; got_done = 1'b0; cs_low = 1'b0;

    while (!got_done && n < lat + 40) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (poke && n == 20) begin
        start = 1'b1; byte_count = '0; flash_address = 24'hABCDEF;
      end
      if (poke && n == 21) start = 1'b0;
      if (!flash_cs) cs_low = 1'b1;
      if (abort_at != 0 && n == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_cs", flash_cs, 1);
        check("abort_clk", flash_clk, 0);
        check("abort_busy", busy, 0);
        check("abort_we", ram_we, 0);
        check("abort_no_write", nwr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (ram_we != 4'h0) begin
        nwr++;
        if (exp_q.size() == 0) begin
          check("extra_write", ram_we, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", ram_address, e.a);
          check("wr_data", ram_data, e.d);
          check("wr_we", ram_we, e.we);
        end
      end
      if (done) begin
        got_done = 1'b1;
        check("latency", n + 1, lat);
        check("busy_at_done", busy, 0);
        check("cs_at_done", flash_cs, 1);
      end
    end
    if (!got_done) check("timeout_done", 0, 1);
    check("writes_missing", exp_q.size(), 0);
    if (cnt == 0) check("cs_never_low", cs_low, 0);
    else          check("mosi_header", hdr[HDR-1:0], eh[HDR-1:0]);
    if (idle_after) begin
      @(negedge clk);
      check("done_pulse_width", done, 0);
      check("idle_busy", busy, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cs", flash_cs, 1);
    check("rst_clk", flash_clk, 0);
    check("rst_mosi", flash_mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", ram_we, 0);
    check("rst_addr", ram_address, 0);
    check("rst_data", ram_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_xfer(24'h000000, 4, 16'h0010, 1, 0, 0);
    run_xfer(24'h000005, 6, 16'h0010, 1, 0, 0);
    run_xfer(24'h123456, 0, 16'h0200, 1, 0, 0);
    run_xfer(24'h000100, 1, 16'h0020, 1, 1, 0);
    run_xfer(24'h000000, 4, 16'h0030, 0, 0, 1 + 2 * HDR + 20);
    run_xfer(24'h000000, 4, 16'h0010, 1, 0, 0);
    // Address wrap in both RAM and flash, then a start on the done cycle.
    run_xfer(24'hFFFFFE, 8, 16'hFFFF, 0, 0, 0);
    run_xfer(24'h0000F0, 3, 16'h0100, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      run_xfer(24'($urandom), int'($urandom_range(0, 11)), RA'($urandom),
               bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
